// File: rtl/tm1638_display_driver_pkg.sv
// Shared types and word/command constants for the TM1638 display driver.
// The base TM1638 types come first, then the driver-specific definitions.
package tm1638_types;
  typedef logic [7:0] segments_t;
  typedef logic [7:0] leds_t;
endpackage

package tm1638_display_types;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MODE_CMD,
    ADDR,
    PAYLOAD,
    SCAN,
    CTRL
  } state_t;

  localparam int STB_START_BIT = 17;
  localparam int STB_END_BIT   = 16;

  localparam logic [7:0] CMD_DATA_AUTO  = 8'h40;
  localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;
  localparam logic [7:0] CMD_CTRL       = 8'h80;
endpackage

// File: rtl/tm1638_display_driver_if.sv
// Write port toward the downstream SPI FIFO: data word, write strobe and full flag.
interface tm1638_display_driver_if #(
  parameter int DATA_W = 18
);
  logic [DATA_W-1:0] o_Data;
  logic              o_Write;
  logic              i_SPI_FIFO_Full;

  modport master (
    output o_Data,
    output o_Write,
    input  i_SPI_FIFO_Full
  );

  modport slave (
    input  o_Data,
    input  o_Write,
    output i_SPI_FIFO_Full
  );
endinterface

// File: rtl/tm1638_dirty_scan.sv
// Finds the lowest-numbered dirty digit at or above a start index.
module tm1638_dirty_scan #(
  parameter int NUM_DIGITS = 8
) (
  input  logic [NUM_DIGITS-1:0] i_Mask,
  input  logic [2:0]            i_Start,
  output logic [2:0]            o_Index,
  output logic                  o_Found
);

  // Descending walk so the lowest qualifying digit is the one that sticks.
  always_comb begin
    o_Index = '0;
    o_Found = 1'b0;
    for (int g = NUM_DIGITS - 1; g >= 0; g--) begin
      if (i_Mask[g] && (g >= int'(i_Start))) begin
        o_Index = 3'(g);
        o_Found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tm1638_display_driver.sv
// Turns a display image into TM1638 command/data words for the SPI FIFO,
// either as a full auto-increment refresh or as fixed-address dirty updates.
module tm1638_display_driver
  import tm1638_types::*;
  import tm1638_display_types::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter bit DIRTY_ONLY = 1'b0,
  parameter int DATA_W     = 18
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [8*NUM_DIGITS-1:0] i_Segments,
  input  logic [NUM_DIGITS-1:0]   i_Leds,
  input  logic [2:0]              i_Brightness,
  input  logic                    i_Display_On,
  input  logic                    i_Valid,
  tm1638_display_driver_if.master fifo,
  output logic                    o_Busy,
  output state_t                  o_Diag_State,
  output logic [2:0]              o_Diag_Digit
);

  state_t state, state_nxt;
  logic [2:0] digit, digit_nxt;
  logic [1:0] sub, sub_nxt;

  logic                    pending;
  logic [8*NUM_DIGITS-1:0] pend_seg, work_seg, last_seg;
  logic [NUM_DIGITS-1:0]   pend_led, work_led, last_led;
  logic [2:0]              pend_bri, work_bri, last_bri;
  logic                    pend_on, work_on, last_on;
  logic                    last_valid;
  logic [NUM_DIGITS-1:0]   dirty, load_mask;
  logic                    ctrl_dirty, load_ctrl_dirty;

  logic        have_word, st_bit, en_bit, commit, fifo_ok, last_digit, ctrl_send;
  logic [7:0]  wbyte;
  logic [DATA_W-1:0] word;
  segments_t   cur_seg;
  leds_t       cur_led;
  logic [2:0]  scan_idx;
  logic        scan_found;

  tm1638_dirty_scan #(.NUM_DIGITS(NUM_DIGITS)) u_scan (
    .i_Mask  (dirty),
    .i_Start (digit),
    .o_Index (scan_idx),
    .o_Found (scan_found)
  );

  // An invalid last-sent image makes every digit and the control word dirty.
  always_comb begin
    load_mask = '0;
    for (int g = 0; g < NUM_DIGITS; g++) begin
      load_mask[g] = !last_valid
                   || (pend_seg[8*g +: 8] != last_seg[8*g +: 8])
                   || (pend_led[g] != last_led[g]);
    end
  end

  assign load_ctrl_dirty = !last_valid || (pend_bri != last_bri) || (pend_on != last_on);
  assign fifo_ok    = !fifo.i_SPI_FIFO_Full;
  assign last_digit = (digit == 3'(NUM_DIGITS - 1));
  assign ctrl_send  = !DIRTY_ONLY || !last_valid || ctrl_dirty;
  assign cur_seg    = work_seg[{digit, 3'b000} +: 8];
  assign cur_led    = {7'b0, work_led[digit]};

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    sub_nxt   = sub;
    have_word = 1'b0;
    st_bit    = 1'b0;
    en_bit    = 1'b0;
    wbyte     = 8'h00;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_nxt = LOAD;
      end
      LOAD: begin
        digit_nxt = '0;
        sub_nxt   = '0;
        if (DIRTY_ONLY && (load_mask == '0))
          state_nxt = load_ctrl_dirty ? CTRL : IDLE;
        else
          state_nxt = MODE_CMD;
      end
      MODE_CMD: begin
        have_word = 1'b1;
        st_bit    = 1'b1;
        en_bit    = 1'b1;
        wbyte     = DIRTY_ONLY ? CMD_DATA_FIXED : CMD_DATA_AUTO;
        if (fifo_ok) state_nxt = DIRTY_ONLY ? SCAN : ADDR;
      end
      ADDR: begin
        have_word = 1'b1;
        st_bit    = 1'b1;
        wbyte     = CMD_ADDR;
        if (fifo_ok) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        have_word = 1'b1;
        if (!DIRTY_ONLY) begin
          wbyte  = sub[0] ? cur_led : cur_seg;
          en_bit = sub[0] && last_digit;
          if (fifo_ok) begin
            if (!sub[0]) begin
              sub_nxt = 2'd1;
            end else if (last_digit) begin
              state_nxt = CTRL;
            end else begin
              digit_nxt = digit + 3'd1;
              sub_nxt   = 2'd0;
            end
          end
        end else begin
          // Four words per digit: seg address, seg byte, LED address, LED byte.
          case (sub)
            2'd0: begin st_bit = 1'b1; wbyte = CMD_ADDR | {4'b0, digit, 1'b0}; end
            2'd1: begin en_bit = 1'b1; wbyte = cur_seg; end
            2'd2: begin st_bit = 1'b1; wbyte = CMD_ADDR | {4'b0, digit, 1'b1}; end
            default: begin en_bit = 1'b1; wbyte = cur_led; end
          endcase
          if (fifo_ok) begin
            sub_nxt = sub + 2'd1;
            if (sub == 2'd3) begin
              if (last_digit) begin
                state_nxt = CTRL;
              end else begin
                digit_nxt = digit + 3'd1;
                state_nxt = SCAN;
              end
            end
          end
        end
      end
      SCAN: begin
        if (scan_found) begin
          digit_nxt = scan_idx;
          sub_nxt   = 2'd0;
          state_nxt = PAYLOAD;
        end else begin
          state_nxt = CTRL;
        end
      end
      CTRL: begin
        if (ctrl_send) begin
          have_word = 1'b1;
          st_bit    = 1'b1;
          en_bit    = 1'b1;
          wbyte     = CMD_CTRL | {4'b0, work_on, work_bri};
          if (fifo_ok) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    word                = '0;
    word[STB_START_BIT] = st_bit;
    word[STB_END_BIT]   = en_bit;
    word[7:0]           = wbyte;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      digit      <= '0;
      sub        <= '0;
      pending    <= 1'b0;
      pend_seg   <= '0;
      pend_led   <= '0;
      pend_bri   <= '0;
      pend_on    <= 1'b0;
      work_seg   <= '0;
      work_led   <= '0;
      work_bri   <= '0;
      work_on    <= 1'b0;
      last_seg   <= '0;
      last_led   <= '0;
      last_bri   <= '0;
      last_on    <= 1'b0;
      last_valid <= 1'b0;
      dirty      <= '0;
      ctrl_dirty <= 1'b0;
    end else begin
      state <= state_nxt;
      digit <= digit_nxt;
      sub   <= sub_nxt;
      // A strobe in the LOAD cycle itself re-arms pending with the newer image.
      if (i_Valid) begin
        pend_seg <= i_Segments;
        pend_led <= i_Leds;
        pend_bri <= i_Brightness;
        pend_on  <= i_Display_On;
        pending  <= 1'b1;
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end
      if (state == LOAD) begin
        work_seg   <= pend_seg;
        work_led   <= pend_led;
        work_bri   <= pend_bri;
        work_on    <= pend_on;
        dirty      <= load_mask;
        ctrl_dirty <= load_ctrl_dirty;
      end
      if (commit) begin
        last_seg   <= work_seg;
        last_led   <= work_led;
        last_bri   <= work_bri;
        last_on    <= work_on;
        last_valid <= 1'b1;
      end
    end
  end

  assign fifo.o_Data  = word;
  assign fifo.o_Write = have_word && fifo_ok;
  assign o_Busy       = (state != IDLE) || pending;
  assign o_Diag_State = state;
  assign o_Diag_Digit = digit;

endmodule

// File: tb/tb_tm1638_display_driver.sv
// Drives a full-refresh and a dirty-only driver with the same images and
// compares their FIFO word streams against a frame-level reference model.
module tb_tm1638_display_driver;
  import tm1638_display_types::*;

  logic        r_Clk = 1'b0;
  logic        r_Rst = 1'b1;
  logic [63:0] r_Segments = '0;
  logic [7:0]  r_Leds = '0;
  logic [2:0]  r_Brightness = '0;
  logic        r_Display_On = 1'b0;
  logic        r_Valid = 1'b0;

  logic        busy_f, busy_d;
  state_t      diag_state_f, diag_state_d;
  logic [2:0]  diag_digit_f, diag_digit_d;

  tm1638_display_driver_if #(.DATA_W(18)) if_f ();
  tm1638_display_driver_if #(.DATA_W(18)) if_d ();

  tm1638_display_driver #(.NUM_DIGITS(8), .DIRTY_ONLY(1'b0), .DATA_W(18)) dut_f (
    .i_Clk(r_Clk), .i_Rst(r_Rst), .i_Segments(r_Segments), .i_Leds(r_Leds),
    .i_Brightness(r_Brightness), .i_Display_On(r_Display_On), .i_Valid(r_Valid),
    .fifo(if_f.master), .o_Busy(busy_f), .o_Diag_State(diag_state_f), .o_Diag_Digit(diag_digit_f)
  );

  tm1638_display_driver #(.NUM_DIGITS(8), .DIRTY_ONLY(1'b1), .DATA_W(18)) dut_d (
    .i_Clk(r_Clk), .i_Rst(r_Rst), .i_Segments(r_Segments), .i_Leds(r_Leds),
    .i_Brightness(r_Brightness), .i_Display_On(r_Display_On), .i_Valid(r_Valid),
    .fifo(if_d.master), .o_Busy(busy_d), .o_Diag_State(diag_state_d), .o_Diag_Digit(diag_digit_d)
  );

  always #5 r_Clk = ~r_Clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_full_viol = 0;
  int busy_d_cycles;
  bit toggle_en = 1'b0;

  logic [17:0] got_f[$], got_d[$], exp_f[$], exp_d[$];

  // current image
  logic [7:0] img_seg[8];
  logic       img_led[8];
  logic [2:0] img_bri;
  logic       img_on;

  // last image the dirty-only driver is known to have sent
  logic [7:0] m_seg[8];
  logic       m_led[8];
  logic [2:0] m_bri;
  logic       m_on;
  bit         m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] w(input bit s, input bit e, input logic [7:0] b);
    return {s, e, 8'h00, b};
  endfunction

  function automatic logic [7:0] ctrl_byte();
    return 8'(128 + 8 * int'(img_on) + int'(img_bri));
  endfunction

  task automatic model_full();
    exp_f.push_back(w(1, 1, 8'h40));
    exp_f.push_back(w(1, 0, 8'hC0));
    for (int g = 0; g < 8; g++) begin
      exp_f.push_back(w(0, 0, img_seg[g]));
      exp_f.push_back(w(0, g == 7, {7'b0, img_led[g]}));
    end
    exp_f.push_back(w(1, 1, ctrl_byte()));
  endtask

  task automatic model_dirty();
    int dl[$];
    bit cd;
    for (int g = 0; g < 8; g++)
      if (!m_valid || img_seg[g] != m_seg[g] || img_led[g] != m_led[g]) dl.push_back(g);
    cd = !m_valid || img_bri != m_bri || img_on != m_on;
    if (dl.size() > 0) begin
      exp_d.push_back(w(1, 1, 8'h44));
      foreach (dl[k]) begin
        exp_d.push_back(w(1, 0, 8'(192 + 2 * dl[k])));
        exp_d.push_back(w(0, 1, img_seg[dl[k]]));
        exp_d.push_back(w(1, 0, 8'(193 + 2 * dl[k])));
        exp_d.push_back(w(0, 1, {7'b0, img_led[dl[k]]}));
      end
    end
    if (cd) exp_d.push_back(w(1, 1, ctrl_byte()));
    for (int g = 0; g < 8; g++) begin
      m_seg[g] = img_seg[g];
      m_led[g] = img_led[g];
    end
    m_bri = img_bri;
    m_on = img_on;
    m_valid = 1'b1;
  endtask

  always @(negedge r_Clk) begin
    if (if_f.o_Write) begin
      got_f.push_back(if_f.o_Data);
      if (if_f.i_SPI_FIFO_Full) wr_full_viol++;
    end
    if (if_d.o_Write) begin
      got_d.push_back(if_d.o_Data);
      if (if_d.i_SPI_FIFO_Full) wr_full_viol++;
    end
  end

  // Backpressure changes only just after a rising edge, at random spacing.
  initial begin
    if_f.i_SPI_FIFO_Full = 1'b0;
    if_d.i_SPI_FIFO_Full = 1'b0;
    forever begin
      repeat ($urandom_range(2, 12)) @(posedge r_Clk);
      #1;
      if (toggle_en) begin
        if ($urandom_range(0, 1) == 1) if_f.i_SPI_FIFO_Full = ~if_f.i_SPI_FIFO_Full;
        if ($urandom_range(0, 1) == 1) if_d.i_SPI_FIFO_Full = ~if_d.i_SPI_FIFO_Full;
      end else begin
        if_f.i_SPI_FIFO_Full = 1'b0;
        if_d.i_SPI_FIFO_Full = 1'b0;
      end
    end
  end

  task automatic drive_image();
    for (int g = 0; g < 8; g++) begin
      r_Segments[8*g +: 8] = img_seg[g];
      r_Leds[g] = img_led[g];
    end
    r_Brightness = img_bri;
    r_Display_On = img_on;
  endtask

  task automatic send_image();
    @(posedge r_Clk);
    #1;
    drive_image();
    r_Valid = 1'b1;
    @(posedge r_Clk);
    #1;
    r_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    busy_d_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge r_Clk);
      if (busy_d) busy_d_cycles++;
      if (!busy_f && !busy_d) break;
    end
    check({tag, "_idle"}, {31'b0, busy_f | busy_d}, 32'd0);
  endtask

  task automatic compare(input string tag);
    check({tag, "_f_len"}, got_f.size(), exp_f.size());
    for (int i = 0; i < got_f.size() && i < exp_f.size(); i++)
      check($sformatf("%s_f_w%0d", tag, i), {14'b0, got_f[i]}, {14'b0, exp_f[i]});
    check({tag, "_d_len"}, got_d.size(), exp_d.size());
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
      check($sformatf("%s_d_w%0d", tag, i), {14'b0, got_d[i]}, {14'b0, exp_d[i]});
    got_f.delete(); got_d.delete(); exp_f.delete(); exp_d.delete();
  endtask

  task automatic run_frame(input string tag);
    send_image();
    model_full();
    model_dirty();
    wait_idle(tag);
    compare(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_f"}, {31'b0, if_f.o_Write}, 32'd0);
    check({tag, "_wr_d"}, {31'b0, if_d.o_Write}, 32'd0);
    check({tag, "_data_f"}, {14'b0, if_f.o_Data}, 32'd0);
    check({tag, "_data_d"}, {14'b0, if_d.o_Data}, 32'd0);
    check({tag, "_busy_f"}, {31'b0, busy_f}, 32'd0);
    check({tag, "_busy_d"}, {31'b0, busy_d}, 32'd0);
    check({tag, "_st_f"}, 32'(diag_state_f), 32'(IDLE));
    check({tag, "_st_d"}, 32'(diag_state_d), 32'(IDLE));
    check({tag, "_dig_f"}, {29'b0, diag_digit_f}, 32'd0);
    check({tag, "_dig_d"}, {29'b0, diag_digit_d}, 32'd0);
  endtask

  task automatic randomize_image(input int chg_pct);
    for (int g = 0; g < 8; g++) begin
      if ($urandom_range(0, 99) < chg_pct) begin
        img_seg[g] = 8'($urandom);
        img_led[g] = 1'($urandom);
      end
    end
    if ($urandom_range(0, 3) == 0) img_bri = 3'($urandom);
    if ($urandom_range(0, 5) == 0) img_on = ~img_on;
  endtask

  initial begin
    logic [7:0] led_pat;
    led_pat = 8'hA5;
    for (int g = 0; g < 8; g++) begin
      img_seg[g] = 8'h3F;
      img_led[g] = led_pat[g];
    end
    img_bri = 3'd7;
    img_on = 1'b1;

    repeat (3) @(posedge r_Clk);
    #1;
    check_reset_outputs("rst");
    r_Rst = 1'b0;
    @(negedge r_Clk);
    check_reset_outputs("post_rst");

    run_frame("first");

    img_seg[3] = 8'h06;
    run_frame("dig3");

    run_frame("same");
    check("same_busy_le2", {31'b0, busy_d_cycles <= 2}, 32'd1);

    img_bri = 3'd2;
    run_frame("bright");

    toggle_en = 1'b1;
    for (int g = 0; g < 8; g++) img_seg[g] = 8'($urandom);
    run_frame("bp_full");
    for (int n = 0; n < 6; n++) begin
      randomize_image(30);
      run_frame($sformatf("bp_rand%0d", n));
    end
    toggle_en = 1'b0;
    repeat (14) @(posedge r_Clk);

    // Three strobes while busy: only the last one survives as the next frame.
    for (int g = 0; g < 8; g++) img_seg[g] = ~img_seg[g];
    send_image();
    model_full();
    model_dirty();
    repeat (4) @(posedge r_Clk);
    for (int p = 0; p < 3; p++) begin
      randomize_image(60);
      #1;
      drive_image();
      r_Valid = 1'b1;
      @(posedge r_Clk);
    end
    #1;
    r_Valid = 1'b0;
    model_full();
    model_dirty();
    wait_idle("coalesce");
    compare("coalesce");

    // Abort mid-frame; the following frame must resend everything.
    for (int g = 0; g < 8; g++) img_seg[g] = ~img_seg[g];
    send_image();
    repeat (6) @(posedge r_Clk);
    #1;
    r_Rst = 1'b1;
    @(posedge r_Clk);
    #1;
    check_reset_outputs("midrst");
    r_Rst = 1'b0;
    got_f.delete(); got_d.delete(); exp_f.delete(); exp_d.delete();
    m_valid = 1'b0;
    run_frame("resend");

    check("wr_while_full", wr_full_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
